pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Parametrised successor to the fetch-stage PC register. Holds the fetch PC and advances it sequentially. Applies prioritised redirects (exception, branch, jump) and honours pipeline stall via `en`. A redirect that arrives during a stall is latched and applied when the stall releases. Sits at the head of the fetch stage, drives the instruction-memory address and the IF/ID flush.

Parameters:
PC_W, 9, PC width in bits; all PC arithmetic is modulo 2^PC_W
INC, 1, sequential increment (1 = word-addressed instruction memory)
RESET_VEC, 0, PC value loaded on reset; first fetched address
EXC_VEC, 9'h180, exception handler address

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  1 = pipeline advancing, 0 = stall (hold PC)
exc_req  in  1  exception redirect request (highest priority)
br_taken  in  1  branch-taken redirect request
br_target  in  PC_W  branch target
jmp  in  1  jump redirect request
jmp_target  in  PC_W  jump target
pcf  out  PC_W  current fetch PC (registered)
pc_plus  out  PC_W  pcf + INC (combinational, wraps)
fetch_valid  out  1  pcf holds a valid fetch address this cycle (registered)
flush_if  out  1  one-cycle pulse: squash instruction in IF/ID (registered)
redirect_pending  out  1  a redirect is latched and waiting for en (registered)

Behaviour:
- Reset (async, any state, mid-operation included): pcf=RESET_VEC, state=BOOT, pend_pc=0, pend_exc=0, fetch_valid=0, flush_if=0, redirect_pending=0.
- Request priority, evaluated each cycle: exc_req > br_taken > jmp > sequential. The next-PC candidates are EXC_VEC, br_target, jmp_target and pcf+INC respectively.
- Width rule: pcf+INC is truncated to PC_W bits, so it wraps (2^PC_W-1 wraps to INC-1).
- FSM states: BOOT, RUN, HOLD.
- BOOT:
  - One cycle after reset deassertion, regardless of en or requests. Requests in this cycle are ignored.
  - fetch_valid=0. Next edge: state goes to RUN, pcf stays RESET_VEC, fetch_valid goes to 1.
- RUN, en=1:
  - pcf takes the selected next PC.
  - If any redirect was selected, flush_if=1 on the next cycle, else 0.
  - State stays RUN.
- RUN, en=0, no request: pcf, flush_if=0 and state are all held.
- RUN, en=0, with a request:
  - pcf is held.
  - pend_pc takes the selected target and pend_exc takes exc_req.
  - redirect_pending goes to 1 and state goes to HOLD.
- HOLD, en=0:
  - pcf is held.
  - exc_req=1 with pend_exc=0: pend_pc goes to EXC_VEC and pend_exc goes to 1.
  - br_taken and jmp are ignored (the pipeline is frozen, so the request is a duplicate).
- HOLD, en=1:
  - pcf takes EXC_VEC if exc_req=1 this cycle, else pend_pc.
  - flush_if pulses to 1 for one cycle.
  - redirect_pending goes to 0 and state goes to RUN.
- flush_if never stays high more than one cycle without a new accepted redirect. Back-to-back redirects with en=1 give back-to-back pulses.
- Redirect-to-PC latency: 1 edge when en=1. When stalled, 1 edge after en rises.
- No X propagation: targets are sampled only when their request bit is 1.

Decomposition:
- Shared package pc_pkg holds:
  - fsm state encoding: BOOT=2'd0, RUN=2'd1, HOLD=2'd2
  - redirect-source encoding: SRC_SEQ, SRC_JMP, SRC_BR, SRC_EXC
  - default EXC_VEC and RESET_VEC constants
- One natural combinational sub-module, pc_next_sel: takes the request bits, the targets and pcf+INC, and outputs next_pc, redirect and src.
- The FSM, pend_pc/pend_exc registers and output registers stay in pc_fetch_unit.

Test Plan:
1. Reset, then en=1 for 4 cycles, no requests -> BOOT: pcf=0, fetch_valid=0; then pcf sequence 0,1,2,3 with fetch_valid=1 and flush_if=0 throughout.
2. pcf=5, en=1, br_taken=1, br_target=0x40 -> next cycle pcf=0x40, flush_if=1; following cycle pcf=0x41, flush_if=0.
3. Same cycle exc_req=1, br_taken=1 (0x40), jmp=1 (0x20) -> pcf=0x180, flush_if=1. Then br_taken+jmp only -> pcf=0x40.
4. en=0 for 3 cycles with jmp=1 (0x20) in the 1st stall cycle and exc_req=1 in the 2nd -> pcf held, redirect_pending=1. On en=1, pcf=0x180, flush_if=1, redirect_pending=0.
5. Start at pcf=0x1FE, en=1 for 3 cycles -> pcf 0x1FF, then 0x000, then 0x001 (wrap).
6. Assert reset asynchronously mid-HOLD (redirect_pending=1) -> all outputs immediately take their reset values, without waiting for a clock edge; after release, BOOT then pcf=0 fetched with no flush_if.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings and default vectors for the fetch-stage PC logic.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_SEQ = 2'd0,
        SRC_JMP = 2'd1,
        SRC_BR  = 2'd2,
        SRC_EXC = 2'd3
    } src_t;

    localparam int DEF_RESET_VEC = 0;
    localparam int DEF_EXC_VEC   = 'h180;

    function automatic logic is_redirect(input src_t s);
        return s != SRC_SEQ;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Prioritised next-PC selection: exception > branch > jump > sequential.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int PC_W    = 9,
    parameter int EXC_VEC = DEF_EXC_VEC
) (
    input  logic            exc_req,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp,
    input  logic [PC_W-1:0] jmp_target,
    input  logic [PC_W-1:0] seq_pc,
    output logic [PC_W-1:0] next_pc,
    output logic            redirect,
    output src_t            src
);

    localparam logic [PC_W-1:0] EXC_PC = PC_W'(EXC_VEC);

    // Targets are only forwarded when their request bit is set, so an X on an
    // idle target bus never reaches the PC.
    always_comb begin
        next_pc = seq_pc;
        src     = SRC_SEQ;
        if (exc_req) begin
            next_pc = EXC_PC;
            src     = SRC_EXC;
        end else if (br_taken) begin
            next_pc = br_target;
            src     = SRC_BR;
        end else if (jmp) begin
            next_pc = jmp_target;
            src     = SRC_JMP;
        end
    end

    assign redirect = is_redirect(src);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register with prioritised redirects, stall handling and a
// pending-redirect latch that replays a redirect seen during a stall.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int PC_W      = 9,
    parameter int INC       = 1,
    parameter int RESET_VEC = DEF_RESET_VEC,
    parameter int EXC_VEC   = DEF_EXC_VEC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            exc_req,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp,
    input  logic [PC_W-1:0] jmp_target,
    output logic [PC_W-1:0] pcf,
    output logic [PC_W-1:0] pc_plus,
    output logic            fetch_valid,
    output logic            flush_if,
    output logic            redirect_pending
);

    localparam logic [PC_W-1:0] RESET_PC = PC_W'(RESET_VEC);
    localparam logic [PC_W-1:0] EXC_PC   = PC_W'(EXC_VEC);
    localparam logic [PC_W-1:0] INC_PC   = PC_W'(INC);

    state_t          state, state_n;
    logic [PC_W-1:0] pend_pc, pend_pc_n;
    logic            pend_exc, pend_exc_n;
    logic [PC_W-1:0] pcf_n;
    logic            valid_n, flush_n, pending_n;

    logic [PC_W-1:0] next_pc;
    logic            redirect;
    src_t            src;

    assign pc_plus = pcf + INC_PC;

    pc_next_sel #(
        .PC_W   (PC_W),
        .EXC_VEC(EXC_VEC)
    ) u_next_sel (
        .exc_req   (exc_req),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jmp       (jmp),
        .jmp_target(jmp_target),
        .seq_pc    (pc_plus),
        .next_pc   (next_pc),
        .redirect  (redirect),
        .src       (src)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        pcf_n      = pcf;
        pend_pc_n  = pend_pc;
        pend_exc_n = pend_exc;
        valid_n    = fetch_valid;
        flush_n    = 1'b0;
        pending_n  = redirect_pending;
        unique case (state)
            BOOT: begin
                state_n = RUN;
                valid_n = 1'b1;
            end
            RUN: begin
                if (en) begin
                    pcf_n   = next_pc;
                    flush_n = redirect;
                end else if (redirect) begin
                    pend_pc_n  = next_pc;
                    pend_exc_n = (src == SRC_EXC);
                    pending_n  = 1'b1;
                    state_n    = HOLD;
                end
            end
            HOLD: begin
                // Branch/jump repeats while frozen are duplicates; only a new
                // exception may override what is already latched.
                if (en) begin
                    pcf_n     = exc_req ? EXC_PC : pend_pc;
                    flush_n   = 1'b1;
                    pending_n = 1'b0;
                    state_n   = RUN;
                end else if (exc_req && !pend_exc) begin
                    pend_pc_n  = EXC_PC;
                    pend_exc_n = 1'b1;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcf              <= RESET_PC;
            pend_pc          <= '0;
            pend_exc         <= 1'b0;
            fetch_valid      <= 1'b0;
            flush_if         <= 1'b0;
            redirect_pending <= 1'b0;
        end else begin
            pcf              <= pcf_n;
            pend_pc          <= pend_pc_n;
            pend_exc         <= pend_exc_n;
            fetch_valid      <= valid_n;
            flush_if         <= flush_n;
            redirect_pending <= pending_n;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scenario-driven bench for pc_fetch_unit with a queue-based scoreboard.
module tb_pc_fetch_unit;

    localparam int PC_W = 9;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    typedef logic [2*PC_W+2:0] obs_t;

    typedef struct packed {
        logic            en;
        logic            exc;
        logic            br;
        logic [PC_W-1:0] bt;
        logic            jmp;
        logic [PC_W-1:0] jt;
        logic [PC_W-1:0] pc;
        logic            fv;
        logic            fl;
        logic            rp;
    } step_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            en, exc_req, br_taken, jmp;
    logic [PC_W-1:0] br_target, jmp_target;
    logic [PC_W-1:0] pcf, pc_plus;
    logic            fetch_valid, flush_if, redirect_pending;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .PC_W     (PC_W),
        .INC      (1),
        .RESET_VEC(0),
        .EXC_VEC  ('h180)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .exc_req         (exc_req),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .jmp             (jmp),
        .jmp_target      (jmp_target),
        .pcf             (pcf),
        .pc_plus         (pc_plus),
        .fetch_valid     (fetch_valid),
        .flush_if        (flush_if),
        .redirect_pending(redirect_pending)
    );

    function automatic obs_t mk(input logic [PC_W-1:0] pc, input logic fv, input logic fl,
                                input logic rp);
        logic [PC_W-1:0] nxt;
        nxt = pc + 9'd1;
        return {pc, nxt, fv, fl, rp};
    endfunction

    function automatic obs_t observed();
        return {pcf, pc_plus, fetch_valid, flush_if, redirect_pending};
    endfunction

    task automatic drive(input step_t s);
        en         = s.en;
        exc_req    = s.exc;
        br_taken   = s.br;
        br_target  = s.bt;
        jmp        = s.jmp;
        jmp_target = s.jt;
    endtask

    task automatic test_reset();
        obs_t got, want;
        reset = 1'b1;
        drive('{N, N, N, 9'h000, N, 9'h000, 9'h000, N, N, N});
        exp_q.push_back(mk(9'h000, N, N, N));
        #2;
        got = observed(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_state got %h expected %h", got, want);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.push_back(mk(9'h000, N, N, N));
        got = observed(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL boot_state got %h expected %h", got, want);
        end
    endtask

    task automatic test_sequential();
        obs_t got, want;
        step_t tbl [4];
        tbl = '{'{Y, N, N, 9'h000, N, 9'h000, 9'h000, Y, N, N},
                '{Y, N, N, 9'h000, N, 9'h000, 9'h001, Y, N, N},
                '{Y, N, N, 9'h000, N, 9'h000, 9'h002, Y, N, N},
                '{Y, N, N, 9'h000, N, 9'h000, 9'h003, Y, N, N}};
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i]);
            exp_q.push_back(mk(tbl[i].pc, tbl[i].fv, tbl[i].fl, tbl[i].rp));
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL sequential[%0d] got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_branch();
        obs_t got, want;
        step_t tbl [4];
        tbl = '{'{Y, N, N, 9'h000, N, 9'h000, 9'h004, Y, N, N},
                '{Y, N, N, 9'h000, N, 9'h000, 9'h005, Y, N, N},
                '{Y, N, Y, 9'h040, N, 9'h000, 9'h040, Y, Y, N},
                '{Y, N, N, 9'h000, N, 9'h000, 9'h041, Y, N, N}};
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i]);
            exp_q.push_back(mk(tbl[i].pc, tbl[i].fv, tbl[i].fl, tbl[i].rp));
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL branch[%0d] got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, want;
        step_t tbl [4];
        tbl = '{'{Y, Y, Y, 9'h040, Y, 9'h020, 9'h180, Y, Y, N},
                '{Y, N, Y, 9'h040, Y, 9'h020, 9'h040, Y, Y, N},
                '{Y, N, N, 9'h000, Y, 9'h020, 9'h020, Y, Y, N},
                '{Y, N, N, 9'h000, N, 9'h000, 9'h021, Y, N, N}};
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i]);
            exp_q.push_back(mk(tbl[i].pc, tbl[i].fv, tbl[i].fl, tbl[i].rp));
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL priority[%0d] got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_stall_exc();
        obs_t got, want;
        step_t tbl [8];
        tbl = '{'{N, N, N, 9'h000, N, 9'h000, 9'h021, Y, N, N},
                '{N, N, N, 9'h000, N, 9'h000, 9'h021, Y, N, N},
                '{Y, N, N, 9'h000, N, 9'h000, 9'h022, Y, N, N},
                '{N, N, N, 9'h000, Y, 9'h020, 9'h022, Y, N, Y},
                '{N, Y, N, 9'h000, N, 9'h000, 9'h022, Y, N, Y},
                '{N, N, N, 9'h000, N, 9'h000, 9'h022, Y, N, Y},
                '{Y, N, N, 9'h000, N, 9'h000, 9'h180, Y, Y, N},
                '{Y, N, N, 9'h000, N, 9'h000, 9'h181, Y, N, N}};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i]);
            exp_q.push_back(mk(tbl[i].pc, tbl[i].fv, tbl[i].fl, tbl[i].rp));
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL stall_exc[%0d] got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_stall_branch();
        obs_t got, want;
        step_t tbl [7];
        tbl = '{'{N, N, Y, 9'h040, N, 9'h000, 9'h181, Y, N, Y},
                '{N, N, Y, 9'h077, N, 9'h000, 9'h181, Y, N, Y},
                '{Y, N, Y, 9'h077, N, 9'h000, 9'h040, Y, Y, N},
                '{Y, N, N, 9'h000, N, 9'h000, 9'h041, Y, N, N},
                '{N, N, N, 9'h000, Y, 9'h030, 9'h041, Y, N, Y},
                '{Y, Y, N, 9'h000, N, 9'h000, 9'h180, Y, Y, N},
                '{Y, N, N, 9'h000, N, 9'h000, 9'h181, Y, N, N}};
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i]);
            exp_q.push_back(mk(tbl[i].pc, tbl[i].fv, tbl[i].fl, tbl[i].rp));
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL stall_branch[%0d] got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_wrap();
        obs_t got, want;
        step_t tbl [4];
        tbl = '{'{Y, N, N, 9'h000, Y, 9'h1FE, 9'h1FE, Y, Y, N},
                '{Y, N, N, 9'h000, N, 9'h000, 9'h1FF, Y, N, N},
                '{Y, N, N, 9'h000, N, 9'h000, 9'h000, Y, N, N},
                '{Y, N, N, 9'h000, N, 9'h000, 9'h001, Y, N, N}};
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i]);
            exp_q.push_back(mk(tbl[i].pc, tbl[i].fv, tbl[i].fl, tbl[i].rp));
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL wrap[%0d] got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_async_reset_hold();
        obs_t got, want;
        step_t tbl [3];
        tbl = '{'{N, N, N, 9'h000, Y, 9'h055, 9'h001, Y, N, Y},
                '{Y, N, N, 9'h000, Y, 9'h055, 9'h000, Y, N, N},
                '{Y, N, N, 9'h000, N, 9'h000, 9'h001, Y, N, N}};
        drive(tbl[0]);
        exp_q.push_back(mk(tbl[0].pc, tbl[0].fv, tbl[0].fl, tbl[0].rp));
        @(posedge clk); #1;
        got = observed(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL enter_hold got %h expected %h", got, want);
        end
        #3;
        reset = 1'b1;
        exp_q.push_back(mk(9'h000, N, N, N));
        #1;
        got = observed(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL async_reset got %h expected %h", got, want);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 1; i < 3; i++) begin
            drive(tbl[i]);
            if (i == 1) begin
                exp_q.push_back(mk(9'h000, N, N, N));
                got = observed(); want = exp_q.pop_front();
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL reboot_state got %h expected %h", got, want);
                end
            end
            exp_q.push_back(mk(tbl[i].pc, tbl[i].fv, tbl[i].fl, tbl[i].rp));
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reboot[%0d] got %h expected %h", i, got, want);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_back_to_back();
        test_stall_exc();
        test_stall_branch();
        test_wrap();
        test_async_reset_hold();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
